// File: rtl/event_debouncer.sv
// Two-channel event debouncer with per-channel sync + FSM.
// Rejected transitions are tallied in a shared saturating counter.
module event_debouncer #(
  parameter int unsigned DEBOUNCE_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic       glitch_clr,
  output logic       event_a,
  output logic       event_b,
  output logic       a_rise,
  output logic       b_fall,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    ST_LO,
    CHK_HI,
    ST_HI,
    CHK_LO
  } st_e;

  localparam logic [7:0] LAST = 8'(DEBOUNCE_LEN - 1);

  logic [1:0] s1_q;
  logic [1:0] s2_q;
  st_e        st_q  [2];
  st_e        st_d  [2];
  logic [7:0] cnt_q [2];
  logic [7:0] cnt_d [2];
  logic [1:0] rej;
  logic       a_rise_q;
  logic       a_rise_d;
  logic       b_fall_q;
  logic       b_fall_d;
  logic [7:0] glitch_q;
  logic [7:0] glitch_d;
  logic [1:0] rej_sum;
  logic [8:0] glitch_sum;

  // Two-flop synchronizers, channel 0 = A, channel 1 = B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {raw_b, raw_a};
      s2_q <= s1_q;
    end
  end

  // Per-channel debounce next-state and rejection detection.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      rej[i]   = 1'b0;
      unique case (st_q[i])
        ST_LO: begin
          if (s2_q[i]) begin
            st_d[i]  = CHK_HI;
            cnt_d[i] = 8'd1;
          end
        end
        CHK_HI: begin
          if (!s2_q[i]) begin
            st_d[i] = ST_LO;
            rej[i]  = 1'b1;
          end else if (cnt_q[i] == LAST) begin
            st_d[i] = ST_HI;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end
        ST_HI: begin
          if (!s2_q[i]) begin
            st_d[i]  = CHK_LO;
            cnt_d[i] = 8'd1;
          end
        end
        CHK_LO: begin
          if (s2_q[i]) begin
            st_d[i] = ST_HI;
            rej[i]  = 1'b1;
          end else if (cnt_q[i] == LAST) begin
            st_d[i] = ST_LO;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
        end
        default: begin
          st_d[i]  = ST_LO;
          cnt_d[i] = 8'd0;
        end
      endcase
    end
  end

  // Channel state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= ST_LO;
        cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Edge pulses and saturating glitch tally next values.
  always_comb begin
    a_rise_d   = (st_q[0] == CHK_HI) && (st_d[0] == ST_HI);
    b_fall_d   = (st_q[1] == CHK_LO) && (st_d[1] == ST_LO);
    rej_sum    = {1'b0, rej[0]} + {1'b0, rej[1]};
    glitch_sum = {1'b0, glitch_q} + {7'd0, rej_sum};
    if (glitch_clr) begin
      glitch_d = {6'd0, rej_sum};
    end else if (glitch_sum[8]) begin
      glitch_d = 8'hFF;
    end else begin
      glitch_d = glitch_sum[7:0];
    end
  end

  // Pulse and tally registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rise_q <= 1'b0;
      b_fall_q <= 1'b0;
      glitch_q <= 8'd0;
    end else begin
      a_rise_q <= a_rise_d;
      b_fall_q <= b_fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign event_a    = (st_q[0] == ST_HI) || (st_q[0] == CHK_LO);
  assign event_b    = (st_q[1] == ST_HI) || (st_q[1] == CHK_LO);
  assign a_rise     = a_rise_q;
  assign b_fall     = b_fall_q;
  assign glitch_cnt = glitch_q;

endmodule
